ram_arb: RTL and testbench

- Arbitrates the single byte-enabled shared RAM port between three requesters:
  - the UART debug loader (byte-wide, no handshake);
  - the CPU instruction-fetch port (req/gnt/rvalid);
  - the CPU data port (req/gnt/rvalid).
- The debug loader has absolute priority. The two CPU ports are served round-robin.
- Sits between the loader/CPU and the RAM macro. It sequences command issue, read latency and ownership handover.

---
 rtl/ram_arb.sv | 166 ++++++++++++++++
 tb/tb_ram_arb.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb.sv
// ram_arb: arbiter for the single shared RAM port.
// Debug loader has absolute priority; fetch and data ports share round-robin.
module ram_arb #(
    parameter int XLEN   = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            dbg_sel_i,
    input  logic [XLEN-1:0] dbg_addr_i,
    input  logic [3:0]      dbg_byte_en_i,
    input  logic [7:0]      dbg_wr_data_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    input  logic            dm_req_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic [3:0]      dm_byte_en_i,
    input  logic [XLEN-1:0] dm_wr_data_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic [XLEN-1:0] rd_data_o,
    input  logic [XLEN-1:0] ram_rd_data_i,
    output logic            ram_sel_o,
    output logic [XLEN-1:0] ram_addr_o,
    output logic [XLEN-1:0] ram_wr_data_o,
    output logic [3:0]      ram_byte_en_o
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RD_WAIT,
        DBG
    } state_e;

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             owner_dm_q;
    logic             last_dm_q;
    logic [XLEN-3:0]  addr_q;
    logic [3:0]       be_q;
    logic [XLEN-1:0]  wdata_q;
    logic             if_gnt_q;
    logic             dm_gnt_q;
    logic             if_rvalid_q;
    logic             dm_rvalid_q;
    logic             win_dm_d;
    logic             unused_lsbs;

    // Data port wins when alone, or on a tie when fetch was served last.
    assign win_dm_d = dm_req_i & (~if_req_i | ~last_dm_q);

    // RAM accesses are word-aligned; the byte offset bits are ignored.
    assign unused_lsbs = ^{dbg_addr_i[1:0], if_addr_i[1:0], dm_addr_i[1:0]};

    // Arbitration FSM: ownership, read-latency countdown and handshake pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_dm_q  <= 1'b0;
            last_dm_q   <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
        end else begin
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (dbg_sel_i) begin
                        state_q <= DBG;
                    end else if (if_req_i | dm_req_i) begin
                        state_q    <= CMD;
                        owner_dm_q <= win_dm_d;
                        last_dm_q  <= win_dm_d;
                        if (win_dm_d) begin
                            addr_q  <= dm_addr_i[XLEN-1:2];
                            be_q    <= dm_byte_en_i;
                            wdata_q <= dm_wr_data_i;
                        end else begin
                            addr_q  <= if_addr_i[XLEN-1:2];
                            be_q    <= 4'b0000;
                            wdata_q <= '0;
                        end
                        if_gnt_q <= ~win_dm_d;
                        dm_gnt_q <= win_dm_d;
                    end
                end
                CMD: begin
                    if (be_q != 4'b0000) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= RD_WAIT;
                        cnt_q   <= CW'(RD_LAT - 1);
                        if (RD_LAT == 1) begin
                            if_rvalid_q <= ~owner_dm_q;
                            dm_rvalid_q <= owner_dm_q;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            if_rvalid_q <= ~owner_dm_q;
                            dm_rvalid_q <= owner_dm_q;
                        end
                    end
                end
                DBG: begin
                    if (!dbg_sel_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RAM command mux: latched CPU command in CMD, debug pass-through in DBG.
    always_comb begin
        ram_sel_o     = 1'b0;
        ram_addr_o    = '0;
        ram_wr_data_o = '0;
        ram_byte_en_o = 4'b0000;
        unique case (state_q)
            CMD: begin
                ram_sel_o     = 1'b1;
                ram_addr_o    = {addr_q, 2'b00};
                ram_wr_data_o = wdata_q;
                ram_byte_en_o = be_q;
            end
            DBG: begin
                ram_sel_o     = dbg_sel_i;
                ram_addr_o    = {dbg_addr_i[XLEN-1:2], 2'b00};
                ram_wr_data_o = {(XLEN/8){dbg_wr_data_i}};
                ram_byte_en_o = dbg_byte_en_i & {4{dbg_sel_i}};
            end
            default: begin
                ram_sel_o = 1'b0;
            end
        endcase
    end

    assign if_gnt_o    = if_gnt_q;
    assign dm_gnt_o    = dm_gnt_q;
    assign if_rvalid_o = if_rvalid_q;
    assign dm_rvalid_o = dm_rvalid_q;
    assign rd_data_o   = ram_rd_data_i;

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: four arbiters with RD_LAT = 1..4 driven from a
// transaction-level model of grant order, RAM command and read timing.
module tb_ram_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        dbg_sel  [1:4];
    logic [31:0] dbg_addr [1:4];
    logic [3:0]  dbg_be   [1:4];
    logic [7:0]  dbg_wd   [1:4];
    logic        if_req   [1:4];
    logic [31:0] if_addr  [1:4];
    logic        if_gnt   [1:4];
    logic        if_rv    [1:4];
    logic        dm_req   [1:4];
    logic [31:0] dm_addr  [1:4];
    logic [3:0]  dm_be    [1:4];
    logic [31:0] dm_wd    [1:4];
    logic        dm_gnt   [1:4];
    logic        dm_rv    [1:4];
    logic [31:0] rd_data  [1:4];
    logic [31:0] ram_rdata[1:4];
    logic        ram_sel  [1:4];
    logic [31:0] ram_addr [1:4];
    logic [31:0] ram_wd   [1:4];
    logic [3:0]  ram_be   [1:4];

    int n_checks = 0;
    int n_fail   = 0;
    bit last_dm [1:4];

    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        logic [31:0] rd_addr;
        ram_arb #(.XLEN(32), .RD_LAT(g)) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .dbg_sel_i     (dbg_sel[g]),
            .dbg_addr_i    (dbg_addr[g]),
            .dbg_byte_en_i (dbg_be[g]),
            .dbg_wr_data_i (dbg_wd[g]),
            .if_req_i      (if_req[g]),
            .if_addr_i     (if_addr[g]),
            .if_gnt_o      (if_gnt[g]),
            .if_rvalid_o   (if_rv[g]),
            .dm_req_i      (dm_req[g]),
            .dm_addr_i     (dm_addr[g]),
            .dm_byte_en_i  (dm_be[g]),
            .dm_wr_data_i  (dm_wd[g]),
            .dm_gnt_o      (dm_gnt[g]),
            .dm_rvalid_o   (dm_rv[g]),
            .rd_data_o     (rd_data[g]),
            .ram_rd_data_i (ram_rdata[g]),
            .ram_sel_o     (ram_sel[g]),
            .ram_addr_o    (ram_addr[g]),
            .ram_wr_data_o (ram_wd[g]),
            .ram_byte_en_o (ram_be[g])
        );
        // RAM model: read address captured at the command, word held after it
        always @(posedge clk)
            if (ram_sel[g] && ram_be[g] == 4'b0000) rd_addr <= ram_addr[g];
        assign ram_rdata[g] = memf(rd_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [72:0] outs(input int k);
        return {if_gnt[k], dm_gnt[k], if_rv[k], dm_rv[k], ram_sel[k],
                ram_addr[k], ram_be[k], ram_wd[k]};
    endfunction

    // Current cycle must be the grant cycle of port dm for instance k.
    task automatic serve(input int k, input bit dm, input string nm);
        logic [31:0] a;
        logic [3:0]  be;
        logic        wr;
        logic        exp_rv;
        int          n;
        a  = dm ? dm_addr[k] : if_addr[k];
        be = dm ? dm_be[k] : 4'b0000;
        wr = (be != 4'b0000);
        n_checks++;
        if ({if_gnt[k], dm_gnt[k]} !== {~dm, dm}) begin
            n_fail++;
            $display("FAIL %s gnt[%0d]: got if=%b dm=%b want if=%b dm=%b",
                     nm, k, if_gnt[k], dm_gnt[k], ~dm, dm);
        end
        n_checks++;
        if ({ram_sel[k], ram_addr[k], ram_be[k]} !== {1'b1, a[31:2], 2'b00, be}) begin
            n_fail++;
            $display("FAIL %s cmd[%0d]: got sel=%b addr=%h be=%b want sel=1 addr=%h be=%b",
                     nm, k, ram_sel[k], ram_addr[k], ram_be[k], {a[31:2], 2'b00}, be);
        end
        if (wr) begin
            n_checks++;
            if (ram_wd[k] !== dm_wd[k]) begin
                n_fail++;
                $display("FAIL %s wdata[%0d]: got %h want %h", nm, k, ram_wd[k], dm_wd[k]);
            end
        end
        if (dm) dm_req[k] = 1'b0;
        else if_req[k] = 1'b0;
        last_dm[k] = dm;
        n = wr ? 1 : k + 1;
        for (int t = 1; t <= n; t++) begin
            tick();
            exp_rv = !wr && (t == k);
            n_checks++;
            if ({if_rv[k], dm_rv[k], if_gnt[k], dm_gnt[k], ram_sel[k]} !==
                {exp_rv & ~dm, exp_rv & dm, 3'b000}) begin
                n_fail++;
                $display("FAIL %s resp[%0d] t=%0d: got rv_if=%b rv_dm=%b gnt=%b%b sel=%b want rv_if=%b rv_dm=%b gnt=00 sel=0",
                         nm, k, t, if_rv[k], dm_rv[k], if_gnt[k], dm_gnt[k], ram_sel[k],
                         exp_rv & ~dm, exp_rv & dm);
            end
            if (exp_rv) begin
                n_checks++;
                if (rd_data[k] !== memf(a)) begin
                    n_fail++;
                    $display("FAIL %s rdata[%0d]: got %h want %h", nm, k, rd_data[k], memf(a));
                end
            end
        end
    endtask

    task automatic cpu_xact(input int k, input bit dm, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd, input string nm);
        if (dm) begin
            dm_addr[k] = a;
            dm_be[k]   = be;
            dm_wd[k]   = wd;
            dm_req[k]  = 1'b1;
        end else begin
            if_addr[k] = a;
            if_req[k]  = 1'b1;
        end
        tick();
        serve(k, dm, nm);
    endtask

    task automatic test_reset();
        tick();
        tick();
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (outs(k) !== '0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got %h want 0", k, outs(k));
            end
        end
        rst = 1'b0;
        tick();
        dm_addr[2] = 32'h100;
        dm_be[2]   = 4'b0000;
        dm_req[2]  = 1'b1;
        tick();
        n_checks++;
        if (dm_gnt[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_gnt: got %b want 1", dm_gnt[2]);
        end
        dm_req[2] = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (outs(2) !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_read: got %h want 0", outs(2));
        end
        tick();
        tick();
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            n_checks++;
            if ({dm_rv[2], if_rv[2]} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_no_rvalid t=%0d: got %b%b want 00", t, dm_rv[2], if_rv[2]);
            end
        end
        for (int k = 1; k <= 4; k++) last_dm[k] = 1'b0;
        cpu_xact(2, 1'b0, 32'h0, 4'b0000, 32'h0, "reset_after_if");
    endtask

    task automatic test_tie();
        bit w0, w, wp, g, rv;
        w0 = !last_dm[1];
        if_addr[1] = 32'h40;
        dm_addr[1] = 32'h80;
        dm_be[1]   = 4'b0000;
        if_req[1]  = 1'b1;
        dm_req[1]  = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            g  = (t % 3 == 1);
            rv = (t % 3 == 2);
            w  = (((t - 1) / 3) % 2 == 0) ? w0 : !w0;
            wp = (((t - 2) / 3) % 2 == 0) ? w0 : !w0;
            n_checks++;
            if ({if_gnt[1], dm_gnt[1], if_rv[1], dm_rv[1]} !==
                {g & ~w, g & w, rv & ~wp, rv & wp}) begin
                n_fail++;
                $display("FAIL tie t=%0d: got gnt=%b%b rv=%b%b want gnt=%b%b rv=%b%b", t,
                         if_gnt[1], dm_gnt[1], if_rv[1], dm_rv[1],
                         g & ~w, g & w, rv & ~wp, rv & wp);
            end
            if (rv) begin
                n_checks++;
                if (rd_data[1] !== memf(wp ? dm_addr[1] : if_addr[1])) begin
                    n_fail++;
                    $display("FAIL tie_rdata t=%0d: got %h want %h", t, rd_data[1],
                             memf(wp ? dm_addr[1] : if_addr[1]));
                end
            end
        end
        if_req[1]  = 1'b0;
        dm_req[1]  = 1'b0;
        last_dm[1] = !w0;
        tick();
    endtask

    task automatic test_write();
        cpu_xact(1, 1'b1, 32'h0000_0013, 4'b0110, 32'hAABB_CCDD, "write");
    endtask

    task automatic test_debug_priority();
        logic [31:0] a;
        logic [3:0]  be;
        logic [7:0]  b;
        dbg_sel[1]  = 1'b1;
        dbg_addr[1] = 32'h22;
        dbg_be[1]   = 4'b0100;
        dbg_wd[1]   = 8'h5A;
        if_addr[1]  = 32'h30;
        if_req[1]   = 1'b1;
        tick();
        n_checks++;
        if ({if_gnt[1], dm_gnt[1], ram_sel[1], ram_addr[1], ram_be[1], ram_wd[1]} !==
            {2'b00, 1'b1, 32'h20, 4'b0100, 32'h5A5A_5A5A}) begin
            n_fail++;
            $display("FAIL dbg_enter: got gnt=%b sel=%b addr=%h be=%b wd=%h want gnt=0 sel=1 addr=20 be=0100 wd=5a5a5a5a",
                     if_gnt[1], ram_sel[1], ram_addr[1], ram_be[1], ram_wd[1]);
        end
        for (int i = 0; i < 4; i++) begin
            a  = $urandom;
            be = 4'($urandom_range(0, 15));
            b  = 8'($urandom);
            dbg_addr[1] = a;
            dbg_be[1]   = be;
            dbg_wd[1]   = b;
            #1;
            n_checks++;
            if ({ram_sel[1], ram_addr[1], ram_be[1], ram_wd[1]} !==
                {1'b1, a[31:2], 2'b00, be, {4{b}}}) begin
                n_fail++;
                $display("FAIL dbg_pass i=%0d: got sel=%b addr=%h be=%b wd=%h want sel=1 addr=%h be=%b wd=%h",
                         i, ram_sel[1], ram_addr[1], ram_be[1], ram_wd[1],
                         {a[31:2], 2'b00}, be, {4{b}});
            end
            tick();
            n_checks++;
            if ({if_gnt[1], if_rv[1]} !== 2'b00) begin
                n_fail++;
                $display("FAIL dbg_hold i=%0d: got gnt=%b rv=%b want 0 0", i, if_gnt[1], if_rv[1]);
            end
        end
        dbg_sel[1] = 1'b0;
        dbg_be[1]  = 4'b0100;
        #1;
        n_checks++;
        if ({ram_sel[1], ram_be[1]} !== 5'b0) begin
            n_fail++;
            $display("FAIL dbg_fall: got sel=%b be=%b want 0 0000", ram_sel[1], ram_be[1]);
        end
        tick();
        n_checks++;
        if ({if_gnt[1], ram_sel[1]} !== 2'b00) begin
            n_fail++;
            $display("FAIL dbg_idle: got gnt=%b sel=%b want 0 0", if_gnt[1], ram_sel[1]);
        end
        tick();
        serve(1, 1'b0, "dbg_release");
        dbg_be[1] = 4'b0000;
    endtask

    task automatic test_debug_during_read();
        bit exp_rv, exp_sel;
        dm_addr[3] = 32'h44;
        dm_be[3]   = 4'b0000;
        dm_req[3]  = 1'b1;
        tick();
        n_checks++;
        if (dm_gnt[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL dbgrd_gnt: got %b want 1", dm_gnt[3]);
        end
        dm_req[3]   = 1'b0;
        dbg_sel[3]  = 1'b1;
        dbg_addr[3] = 32'h80;
        dbg_be[3]   = 4'b1111;
        dbg_wd[3]   = 8'h77;
        for (int t = 1; t <= 6; t++) begin
            tick();
            exp_rv  = (t == 3);
            exp_sel = (t >= 5);
            n_checks++;
            if ({dm_rv[3], if_rv[3], ram_sel[3]} !== {exp_rv, 1'b0, exp_sel}) begin
                n_fail++;
                $display("FAIL dbgrd t=%0d: got rv=%b%b sel=%b want rv=%b0 sel=%b",
                         t, dm_rv[3], if_rv[3], ram_sel[3], exp_rv, exp_sel);
            end
            if (exp_rv) begin
                n_checks++;
                if (rd_data[3] !== memf(32'h44)) begin
                    n_fail++;
                    $display("FAIL dbgrd_rdata: got %h want %h", rd_data[3], memf(32'h44));
                end
            end
            if (exp_sel) begin
                n_checks++;
                if ({ram_addr[3], ram_be[3], ram_wd[3]} !== {32'h80, 4'b1111, 32'h7777_7777}) begin
                    n_fail++;
                    $display("FAIL dbgrd_pass t=%0d: got addr=%h be=%b wd=%h want 80 1111 77777777",
                             t, ram_addr[3], ram_be[3], ram_wd[3]);
                end
            end
        end
        dbg_sel[3] = 1'b0;
        dbg_be[3]  = 4'b0000;
        last_dm[3] = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_lat_sweep();
        for (int k = 1; k <= 4; k++) begin
            cpu_xact(k, 1'($urandom_range(0, 1)), $urandom, 4'b0000, 32'h0, "sweep");
        end
    endtask

    task automatic test_random();
        int k, mask;
        bit w;
        for (int i = 0; i < 60; i++) begin
            k    = $urandom_range(1, 4);
            mask = $urandom_range(1, 3);
            if_addr[k] = $urandom;
            dm_addr[k] = $urandom;
            dm_be[k]   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            dm_wd[k]   = $urandom;
            if_req[k]  = (mask != 2);
            dm_req[k]  = (mask != 1);
            tick();
            w = (mask == 3) ? !last_dm[k] : (mask == 2);
            serve(k, w, "rand");
            if (mask == 3) begin
                tick();
                serve(k, !w, "rand_second");
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            dbg_sel[k]  = 1'b0;
            dbg_addr[k] = '0;
            dbg_be[k]   = '0;
            dbg_wd[k]   = '0;
            if_req[k]   = 1'b0;
            if_addr[k]  = '0;
            dm_req[k]   = 1'b0;
            dm_addr[k]  = '0;
            dm_be[k]    = '0;
            dm_wd[k]    = '0;
            last_dm[k]  = 1'b0;
        end
        test_reset();
        test_tie();
        test_write();
        test_debug_priority();
        test_debug_during_read();
        test_lat_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
